// File: rtl/pwr_seq_pkg.sv
// Shared types and constants for the execution-unit power sequencer.
package pwr_seq_pkg;

  // Width of the shared wait/settle counter
  localparam int CNT_W = 8;

  // Default timing parameters
  localparam int SETTLE_CYCLES_DEF = 8;
  localparam int ACK_TIMEOUT_DEF   = 64;

  // Sequencer states; encodings are visible on seq_state
  typedef enum logic [3:0] {
    ST_ON      = 4'd0,
    ST_SAVE    = 4'd1,
    ST_ISO     = 4'd2,
    ST_PSW_OFF = 4'd3,
    ST_OFF     = 4'd4,
    ST_PSW_ON  = 4'd5,
    ST_SETTLE  = 4'd6,
    ST_RESTORE = 4'd7,
    ST_DEISO   = 4'd8
  } seq_state_e;

  // Registered control outputs, decoded from the state being entered
  typedef struct packed {
    logic save_req;
    logic restore_req;
    logic iso_enable;
    logic psw_on;
    logic dom_rst_n;
    logic domain_on;
  } seq_out_t;

  // Output pattern held while in a given state
  function automatic seq_out_t state_outputs(seq_state_e s);
    seq_out_t o;
    o.save_req    = (s == ST_SAVE);
    o.restore_req = (s == ST_RESTORE);
    o.domain_on   = (s == ST_ON);
    // Clamps stay on from isolation until the domain has been restored
    o.iso_enable  = (s == ST_ISO) || (s == ST_PSW_OFF) || (s == ST_OFF) ||
                    (s == ST_PSW_ON) || (s == ST_SETTLE) || (s == ST_RESTORE);
    o.psw_on      = !((s == ST_PSW_OFF) || (s == ST_OFF));
    // Domain reset held from switch-off until settle has completed
    o.dom_rst_n   = !((s == ST_PSW_OFF) || (s == ST_OFF) ||
                      (s == ST_PSW_ON) || (s == ST_SETTLE));
    return o;
  endfunction

endpackage

// File: rtl/pwr_seq_ctrl.sv
// Power-down/power-up sequencer for the execution-unit power domain.
// One FSM plus a shared counter used both for ack timeouts and settle delay.
module pwr_seq_ctrl
  import pwr_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int ACK_TIMEOUT   = ACK_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pd_req,
  input  logic       save_ack,
  input  logic       restore_ack,
  input  logic       psw_ack,
  output logic       save_req,
  output logic       restore_req,
  output logic       iso_enable,
  output logic       psw_on,
  output logic       dom_rst_n,
  output logic       domain_on,
  output logic [3:0] seq_state,
  output logic       timeout_err
);

  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  seq_out_t         out_q;
  logic             ack_wait;

  // Next-state, counter and timeout-flag logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    ack_wait = 1'b0;
    unique case (state_q)
      ST_ON:      if (pd_req) state_d = ST_SAVE;
      ST_SAVE:    if (save_ack) state_d = pd_req ? ST_ISO : ST_DEISO;
                  else ack_wait = 1'b1;
      ST_ISO:     state_d = pd_req ? ST_PSW_OFF : ST_DEISO;
      ST_PSW_OFF: if (!psw_ack) state_d = ST_OFF;
                  else ack_wait = 1'b1;
      ST_OFF:     if (!pd_req) state_d = ST_PSW_ON;
      ST_PSW_ON:  if (psw_ack) state_d = ST_SETTLE;
                  else ack_wait = 1'b1;
      ST_SETTLE:  if (cnt_q == '0) state_d = ST_RESTORE;
                  else cnt_d = cnt_q - 1'b1;
      ST_RESTORE: if (restore_ack) state_d = ST_DEISO;
                  else ack_wait = 1'b1;
      ST_DEISO:   state_d = ST_ON;
      default:    state_d = ST_ON;
    endcase

    // Count cycles spent waiting; an ack in the same cycle pre-empts the timeout
    if (ack_wait) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_q == TMO_LAST) err_d = 1'b1;
    end

    // Counter restarts on each state change; SETTLE entry preloads the delay
    if (state_d != state_q) cnt_d = (state_d == ST_SETTLE) ? SETTLE_LOAD : '0;
  end

  // State, counter, sticky error and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ON;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      out_q   <= state_outputs(ST_ON);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      out_q   <= state_outputs(state_d);
    end
  end

  assign save_req    = out_q.save_req;
  assign restore_req = out_q.restore_req;
  assign iso_enable  = out_q.iso_enable;
  assign psw_on      = out_q.psw_on;
  assign dom_rst_n   = out_q.dom_rst_n;
  assign domain_on   = out_q.domain_on;
  assign seq_state   = state_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Self-checking bench for pwr_seq_ctrl: randomized PMU requests and ack
// responders, compared every cycle against a behavioural reference model.
module tb_pwr_seq_ctrl;

  localparam int SETTLE = 8;
  localparam int TMO    = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pd_req = 1'b0;
  logic       save_ack = 1'b0;
  logic       restore_ack = 1'b0;
  logic       psw_ack = 1'b1;
  logic       save_req, restore_req, iso_enable, psw_on, dom_rst_n, domain_on;
  logic [3:0] seq_state;
  logic       timeout_err;

  pwr_seq_ctrl #(.SETTLE_CYCLES(SETTLE), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .pd_req(pd_req), .save_ack(save_ack),
    .restore_ack(restore_ack), .psw_ack(psw_ack), .save_req(save_req),
    .restore_req(restore_req), .iso_enable(iso_enable), .psw_on(psw_on),
    .dom_rst_n(dom_rst_n), .domain_on(domain_on), .seq_state(seq_state),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases numbered as the published state codes; m_cyc = cycles already spent in phase.
  int m_state = 0;
  int m_cyc   = 0;
  bit m_err   = 1'b0;

  function automatic bit f_waiting(int s, bit sa, bit ra, bit pa);
    return (s == 1 && !sa) || (s == 3 && pa) || (s == 5 && !pa) || (s == 7 && !ra);
  endfunction

  function automatic int f_next(int s, int cyc, bit pd, bit sa, bit ra, bit pa);
    case (s)
      0:       return pd ? 1 : 0;
      1:       return sa ? (pd ? 2 : 8) : 1;
      2:       return pd ? 3 : 8;
      3:       return pa ? 3 : 4;
      4:       return pd ? 4 : 5;
      5:       return pa ? 6 : 5;
      6:       return (cyc + 1 >= SETTLE) ? 7 : 6;
      7:       return ra ? 8 : 7;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      m_cyc   <= 0;
      m_err   <= 1'b0;
    end else begin
      if (f_waiting(m_state, save_ack, restore_ack, psw_ack) && (m_cyc + 1 == TMO))
        m_err <= 1'b1;
      if (f_next(m_state, m_cyc, pd_req, save_ack, restore_ack, psw_ack) != m_state)
        m_cyc <= 0;
      else
        m_cyc <= m_cyc + 1;
      m_state <= f_next(m_state, m_cyc, pd_req, save_ack, restore_ack, psw_ack);
    end
  end

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    chk("seq_state",   32'(seq_state),   32'(m_state));
    chk("save_req",    32'(save_req),    32'(m_state == 1));
    chk("restore_req", 32'(restore_req), 32'(m_state == 7));
    chk("iso_enable",  32'(iso_enable),  32'(m_state >= 2 && m_state <= 7));
    chk("psw_on",      32'(psw_on),      32'(!(m_state == 3 || m_state == 4)));
    chk("dom_rst_n",   32'(dom_rst_n),   32'(!(m_state >= 3 && m_state <= 6)));
    chk("domain_on",   32'(domain_on),   32'(m_state == 0));
    chk("timeout_err", 32'(timeout_err), 32'(m_err));
  end

  // ---------------- environment ----------------
  int sv_dly = 0;
  int rs_dly = 0;
  int ps_dly = 0;
  bit psw_stuck = 1'b0;

  task automatic env_step();
    if (!save_req) begin
      save_ack = 1'b0;
      sv_dly = $urandom_range(0, 4);
    end else if (!save_ack) begin
      if (sv_dly == 0) save_ack = 1'b1; else sv_dly--;
    end
    if (!restore_req) begin
      restore_ack = 1'b0;
      rs_dly = $urandom_range(0, 4);
    end else if (!restore_ack) begin
      if (rs_dly == 0) restore_ack = 1'b1; else rs_dly--;
    end
    if (psw_stuck) begin
      psw_ack = 1'b1;
    end else if (psw_ack !== psw_on) begin
      if (ps_dly == 0) begin
        psw_ack = psw_on;
        ps_dly = $urandom_range(0, 3);
      end else begin
        ps_dly--;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    env_step();
  endtask

  task automatic wait_state(input int s, input int budget, input string tag);
    int k = 0;
    while (seq_state !== 4'(s) && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(seq_state), 32'(s));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"},  32'(seq_state),   32'd0);
    chk({tag, "_psw"},    32'(psw_on),      32'd1);
    chk({tag, "_iso"},    32'(iso_enable),  32'd0);
    chk({tag, "_drst"},   32'(dom_rst_n),   32'd1);
    chk({tag, "_save"},   32'(save_req),    32'd0);
    chk({tag, "_rest"},   32'(restore_req), 32'd0);
    chk({tag, "_err"},    32'(timeout_err), 32'd0);
    chk({tag, "_don"},    32'(domain_on),   32'd1);
  endtask

  initial begin
    // Reset
    repeat (3) tick();
    chk_reset_values("rst");
    rst_n = 1'b1;

    // Randomized PMU requests
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 24) == 0) pd_req = ~pd_req;
    end

    // Abort in the ISO cycle
    pd_req = 1'b0;
    wait_state(0, 300, "iso_pre_on");
    pd_req = 1'b1;
    wait_state(2, 60, "iso_reach");
    pd_req = 1'b0;
    wait_state(0, 60, "iso_abort_on");

    // Timeout in PSW_OFF, with a pd_req glitch that must not abort
    pd_req = 1'b1;
    wait_state(2, 60, "tmo_iso");
    psw_stuck = 1'b1;
    wait_state(3, 10, "tmo_pswoff");
    tick();
    pd_req = 1'b0;
    repeat (2) tick();
    pd_req = 1'b1;
    repeat (TMO + 10) tick();
    chk("tmo_err",   32'(timeout_err), 32'd1);
    chk("tmo_state", 32'(seq_state),   32'd3);
    psw_stuck = 1'b0;
    wait_state(4, 20, "tmo_off");
    repeat (5) tick();
    chk("tmo_hold_off", 32'(seq_state),   32'd4);
    chk("tmo_sticky",   32'(timeout_err), 32'd1);

    // Asynchronous reset in the middle of SETTLE
    pd_req = 1'b0;
    wait_state(6, 30, "settle_reach");
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1 chk_reset_values("arst");
    tick();
    rst_n = 1'b1;

    // More random traffic after the mid-sequence reset
    for (int i = 0; i < 500; i++) begin
      tick();
      if ($urandom_range(0, 19) == 0) pd_req = ~pd_req;
    end
    pd_req = 1'b0;
    wait_state(0, 300, "final_on");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
